// File: rtl/nn_loop_ctrl.sv
// Loop controller between the phase detector and the DCO: presents each error sample
// (with the previous one) to the NN filter and integrates its output into a saturating control word.
module nn_loop_ctrl #(
  parameter int SETTLE  = 2,
  parameter int CW      = 16,
  parameter int CW_INIT = 32768
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          err_valid,
  input  logic [8:0]    err_in,
  output logic          err_ready,
  input  logic          loop_clr,
  output logic [8:0]    nn_in1,
  output logic [8:0]    nn_in2,
  input  logic [7:0]    nn_out,
  output logic [CW-1:0] ctrl_word,
  output logic          ctrl_valid,
  output logic          sat_pulse
);

  typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

  localparam logic [3:0]    CNT_LOAD = 4'(SETTLE - 1);
  localparam logic [CW-1:0] CW_RST   = CW'(CW_INIT);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [8:0]    nn_in1_q, nn_in1_d;
  logic [8:0]    nn_in2_q, nn_in2_d;
  logic [8:0]    prev_err_q, prev_err_d;
  logic [CW-1:0] ctrl_word_q, ctrl_word_d;
  logic          ctrl_valid_q, ctrl_valid_d;
  logic          sat_pulse_q, sat_pulse_d;

  // Offset-binary nn_out becomes two's complement by inverting its MSB; two guard bits
  // above CW keep both the negative and the overflow side of the sum visible.
  logic signed [CW+1:0] delta_ext;
  logic signed [CW+1:0] sum;

  assign delta_ext = {{(CW-6){~nn_out[7]}}, ~nn_out[7], nn_out[6:0]};
  assign sum       = $signed({2'b00, ctrl_word_q}) + delta_ext;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    nn_in1_d     = nn_in1_q;
    nn_in2_d     = nn_in2_q;
    prev_err_d   = prev_err_q;
    ctrl_word_d  = ctrl_word_q;
    ctrl_valid_d = 1'b0;
    sat_pulse_d  = 1'b0;
    err_ready    = (state_q == ST_IDLE);

    if (loop_clr) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      nn_in1_d    = '0;
      nn_in2_d    = '0;
      prev_err_d  = '0;
      ctrl_word_d = CW_RST;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (err_valid) begin
            nn_in1_d = err_in;
            nn_in2_d = prev_err_q;
            cnt_d    = CNT_LOAD;
            state_d  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            if (sum[CW+1]) begin
              ctrl_word_d = '0;
              sat_pulse_d = 1'b1;
            end else if (sum[CW]) begin
              ctrl_word_d = '1;
              sat_pulse_d = 1'b1;
            end else begin
              ctrl_word_d = sum[CW-1:0];
            end
            ctrl_valid_d = 1'b1;
            prev_err_d   = nn_in1_q;
            state_d      = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      nn_in1_q     <= '0;
      nn_in2_q     <= '0;
      prev_err_q   <= '0;
      ctrl_word_q  <= CW_RST;
      ctrl_valid_q <= 1'b0;
      sat_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nn_in1_q     <= nn_in1_d;
      nn_in2_q     <= nn_in2_d;
      prev_err_q   <= prev_err_d;
      ctrl_word_q  <= ctrl_word_d;
      ctrl_valid_q <= ctrl_valid_d;
      sat_pulse_q  <= sat_pulse_d;
    end
  end

  assign nn_in1     = nn_in1_q;
  assign nn_in2     = nn_in2_q;
  assign ctrl_word  = ctrl_word_q;
  assign ctrl_valid = ctrl_valid_q;
  assign sat_pulse  = sat_pulse_q;

endmodule

// File: tb/tb_nn_loop_ctrl.sv
// Scoreboard bench for nn_loop_ctrl: a behavioural NN stub (delta = err/2) drives nn_out,
// and each accepted sample queues its expected NN inputs, control word, clamp flag and arrival cycle.
module tb_nn_loop_ctrl;
  localparam int SETTLE  = 2;
  localparam int CW      = 16;
  localparam int CW_INIT = 32768;
  localparam int CW_MAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          err_valid;
  logic [8:0]    err_in;
  logic          err_ready;
  logic          loop_clr;
  logic [8:0]    nn_in1;
  logic [8:0]    nn_in2;
  logic [7:0]    nn_out;
  logic [CW-1:0] ctrl_word;
  logic          ctrl_valid;
  logic          sat_pulse;

  typedef struct {
    logic [8:0]    in1;
    logic [8:0]    in2;
    logic [CW-1:0] cw;
    logic          sat;
    int            cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         m_cw  = CW_INIT;
  logic [8:0] m_prev = '0;

  nn_loop_ctrl #(.SETTLE(SETTLE), .CW(CW), .CW_INIT(CW_INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .err_valid  (err_valid),
    .err_in     (err_in),
    .err_ready  (err_ready),
    .loop_clr   (loop_clr),
    .nn_in1     (nn_in1),
    .nn_in2     (nn_in2),
    .nn_out     (nn_out),
    .ctrl_word  (ctrl_word),
    .ctrl_valid (ctrl_valid),
    .sat_pulse  (sat_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // NN stub: offset-binary output of floor(err/2); covers 0..255 over the 9-bit error range.
  function automatic int nn_fn(input int e);
    return 128 + (e >>> 1);
  endfunction

  assign nn_out = 8'(nn_fn(int'($signed(nn_in1))));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    sb.delete();
    m_cw   = CW_INIT;
    m_prev = '0;
  endtask

  // Called at a negedge; returns at the negedge after the handshake. hold keeps err_valid up.
  task automatic send(input logic [8:0] e, input bit hold);
    exp_t x;
    int   s;
    bit   done = 1'b0;
    err_valid = 1'b1;
    err_in    = e;
    for (int i = 0; i < 50 && !done; i++) begin
      if (err_ready && !loop_clr) begin
        @(posedge clk);
        #1;
        done  = 1'b1;
        x.in1 = e;
        x.in2 = m_prev;
        s     = m_cw + nn_fn(int'($signed(e))) - 128;
        x.sat = (s < 0) || (s > CW_MAX);
        m_cw  = (s < 0) ? 0 : (s > CW_MAX) ? CW_MAX : s;
        x.cw  = CW'(m_cw);
        x.cyc = cyc + SETTLE;
        m_prev = e;
        sb.push_back(x);
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      check("handshake_timeout", 32'(done), 32'd1);
      @(negedge clk);
    end else begin
      @(negedge clk);
      check("busy_ready", 32'(err_ready), 32'd0);
    end
    if (!hold) err_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t x;
    if (!rst) begin
      if (ctrl_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 32'(sb.size()), 32'd1);
        end else begin
          x = sb.pop_front();
          check("nn_in1", 32'(nn_in1), 32'(x.in1));
          check("nn_in2", 32'(nn_in2), 32'(x.in2));
          check("ctrl_word", 32'(ctrl_word), 32'(x.cw));
          check("sat_pulse", 32'(sat_pulse), 32'(x.sat));
          check("latency", 32'(cyc), 32'(x.cyc));
        end
      end else if (sat_pulse) begin
        check("sat_orphan", 32'(ctrl_valid), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; err_valid = 1'b0; err_in = '0; loop_clr = 1'b0;
    #12;
    check("rst_ctrl_word", 32'(ctrl_word), 32'd32768);
    check("rst_nn_in1", 32'(nn_in1), 32'd0);
    check("rst_nn_in2", 32'(nn_in2), 32'd0);
    check("rst_ctrl_valid", 32'(ctrl_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_err_ready", 32'(err_ready), 32'd1);

    // Single sample: +20 -> nn_out 138 -> +10.
    send(9'd20, 1'b0);
    drain();
    check("single_cw", 32'(ctrl_word), 32'd32778);

    // History with a held err_valid across SETTLE.
    send(9'd20, 1'b1);
    send(9'h1FB, 1'b0);
    drain();
    check("hist_in1", 32'(nn_in1), 32'h1FB);
    check("hist_in2", 32'(nn_in2), 32'd20);

    // Climb to the top rail, then clamp.
    while (m_cw <= CW_MAX - 127) send(9'd255, 1'b1);
    err_valid = 1'b0;
    send(9'd255, 1'b0);
    send(9'd255, 1'b0);
    drain();
    check("sat_hi_cw", 32'(ctrl_word), 32'hFFFF);

    // Descend to the bottom rail, then clamp.
    while (m_cw >= 128) send(9'h100, 1'b1);
    err_valid = 1'b0;
    send(9'h100, 1'b0);
    drain();
    check("sat_lo_cw", 32'(ctrl_word), 32'd0);

    // Zero delta: ctrl_valid still pulses, word unchanged, no clamp.
    send(9'd1, 1'b0);
    drain();
    check("zero_delta_cw", 32'(ctrl_word), 32'd0);

    // Abort in the first SETTLE cycle.
    send(9'd20, 1'b0);
    loop_clr = 1'b1;
    model_clear();
    @(negedge clk);
    loop_clr = 1'b0;
    check("clr_ready", 32'(err_ready), 32'd1);
    check("clr_cw", 32'(ctrl_word), 32'd32768);
    check("clr_in1", 32'(nn_in1), 32'd0);
    check("clr_in2", 32'(nn_in2), 32'd0);
    repeat (SETTLE + 2) @(negedge clk);

    // Handshake coincident with loop_clr is refused.
    err_valid = 1'b1; err_in = 9'd7; loop_clr = 1'b1;
    @(negedge clk);
    err_valid = 1'b0; loop_clr = 1'b0;
    check("clr_hs_in1", 32'(nn_in1), 32'd0);
    check("clr_hs_ready", 32'(err_ready), 32'd1);
    send(9'h1FB, 1'b0);
    drain();

    // Asynchronous reset between edges while a sample is in flight.
    send(9'd20, 1'b0);
    #2 rst = 1'b1;
    #1;
    model_clear();
    check("arst_cw", 32'(ctrl_word), 32'd32768);
    check("arst_in1", 32'(nn_in1), 32'd0);
    check("arst_in2", 32'(nn_in2), 32'd0);
    check("arst_ready", 32'(err_ready), 32'd1);
    check("arst_valid", 32'(ctrl_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(9'd20, 1'b0);
    drain();
    check("arst_after_cw", 32'(ctrl_word), 32'd32778);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
